// File: rtl/heap_sort_pkg.sv
// Shared types and defaults for the heap-sort controller and its watchdog.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package heap_sort_pkg;

  localparam int DATA_W           = 8;
  localparam int DEF_CAPACITY     = 255;
  localparam int DEF_DONE_TIMEOUT = 64;

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    PUSH_WAIT = 3'd1,
    SETTLE    = 3'd2,
    PRESENT   = 3'd3,
    POP_WAIT  = 3'd4,
    ERR       = 3'd5
  } state_t;

  // True in the states that are waiting on the heap's h_done.
  function automatic logic is_wait_state(input state_t s);
    return (s == PUSH_WAIT) || (s == POP_WAIT);
  endfunction

endpackage

// File: rtl/heap_sort_wdog.sv
// Watchdog for heap operations; compiled only when HEAP_SORT_TIMEOUT_EN is defined.
// Latency: expired asserts LIMIT-1 cycles after the cycle following start, i.e. on the LIMIT-th waiting cycle.
// Backpressure: none; start re-arms, clear disarms, expired holds until cleared or reset.
`ifdef HEAP_SORT_TIMEOUT_EN
module heap_sort_wdog
  import heap_sort_pkg::*;
#(
  parameter int LIMIT = DEF_DONE_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int            CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic          r_armed;
  logic [CW-1:0] r_cnt;

  // Count waiting cycles from the pulse; saturate at the limit so expired stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else if (start) begin
      r_armed <= 1'b1;
      r_cnt   <= '0;
    end else if (clear) begin
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else if (r_armed && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = r_armed && (r_cnt == LAST);

endmodule
`endif

// File: rtl/heap_sort_ctrl.sv
// Batch sorter front end: pushes a batch into an external min-heap, then pops it out ascending.
// Latency: one push per input (waits for h_done); each output follows SETTLE + PRESENT after the previous pop's h_done.
// Backpressure: in_ready only in LOAD below CAPACITY; out_data/out_last held while out_valid && !out_ready.
// Optional watchdog: define HEAP_SORT_TIMEOUT_EN to trap a missing h_done into a sticky ERR state.
module heap_sort_ctrl
  import heap_sort_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic              h_push,
  output logic              h_pop,
  output logic [DATA_W-1:0] h_din,
  input  logic [DATA_W-1:0] h_dout,
  input  logic [DATA_W-1:0] h_size,
  input  logic              h_done,
  input  logic              h_valid
);

  localparam logic [7:0] CAP_L = 8'(CAPACITY);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_count, w_count_nxt;
  logic              r_last, w_last_nxt;
  logic              r_h_push, w_h_push_nxt;
  logic              r_h_pop, w_h_pop_nxt;
  logic [DATA_W-1:0] r_h_din, w_h_din_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic              w_in_ready;
  logic              w_expired;

  assign w_in_ready = (r_state == LOAD) && (r_count < CAP_L);

`ifdef HEAP_SORT_TIMEOUT_EN
  logic w_wd_start;
  logic w_wd_clear;

  // Arm on every heap command; disarm when the waited-for h_done arrives.
  assign w_wd_start = w_h_push_nxt | w_h_pop_nxt;
  assign w_wd_clear = h_done && is_wait_state(r_state);

  heap_sort_wdog #(
    .LIMIT (DONE_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .start   (w_wd_start),
    .clear   (w_wd_clear),
    .expired (w_expired)
  );

  assign err = (r_state == ERR);
`else
  // Watchdog compiled out: expiry can never fire, ERR is unreachable.
  assign w_expired = (DONE_TIMEOUT < 0);
  assign err       = 1'b0;
`endif

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_last_nxt      = r_last;
    w_h_push_nxt    = 1'b0;
    w_h_pop_nxt     = 1'b0;
    w_h_din_nxt     = r_h_din;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;

    case (r_state)
      LOAD: begin
        if (in_valid && w_in_ready) begin
          w_h_din_nxt  = in_data;
          w_h_push_nxt = 1'b1;
          w_last_nxt   = in_last;
          w_count_nxt  = r_count + 8'd1;
          w_state_nxt  = PUSH_WAIT;
        end
      end
      PUSH_WAIT: begin
        if (h_done) begin
          // A full batch drains even without in_last.
          w_state_nxt = (r_last || (r_count == CAP_L)) ? SETTLE : LOAD;
        end else if (w_expired) begin
          w_state_nxt = ERR;
        end
      end
      SETTLE: begin
        // One idle cycle so h_dout/h_size reflect the heap after its last operation.
        w_state_nxt = PRESENT;
      end
      PRESENT: begin
        if (r_out_valid) begin
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_h_pop_nxt     = 1'b1;
            w_state_nxt     = POP_WAIT;
          end
        end else if (h_size == '0) begin
          w_count_nxt = '0;
          w_state_nxt = LOAD;
        end else if (h_valid) begin
          w_out_data_nxt  = h_dout;
          w_out_last_nxt  = (h_size == DATA_W'(1));
          w_out_valid_nxt = 1'b1;
        end
      end
      POP_WAIT: begin
        if (h_done) begin
          w_state_nxt = SETTLE;
        end else if (w_expired) begin
          w_state_nxt = ERR;
        end
      end
      ERR: begin
        w_out_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase

    if (w_state_nxt == ERR) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  // State register and registered outputs; reset abandons any batch in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LOAD;
      r_count     <= '0;
      r_last      <= 1'b0;
      r_h_push    <= 1'b0;
      r_h_pop     <= 1'b0;
      r_h_din     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_last      <= w_last_nxt;
      r_h_push    <= w_h_push_nxt;
      r_h_pop     <= w_h_pop_nxt;
      r_h_din     <= w_h_din_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign h_push    = r_h_push;
  assign h_pop     = r_h_pop;
  assign h_din     = r_h_din;
  assign busy      = (r_count != '0) || (r_state != LOAD);

endmodule

// File: doc/heap_sort_ctrl.md
HEAP_SORT_CTRL -- requirements
Module: heap_sort_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 255, the maximum number of values per batch (1..255).
REQ-002 SHALL have parameter DONE_TIMEOUT, default 64, the watchdog limit in cycles from an h_push/h_pop pulse to h_done.
REQ-003 SHALL have these ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input value offered.
- in_ready  out  1  controller accepts input.
- in_data  in  8  value to sort.
- in_last  in  1  final value of the batch.
- out_valid  out  1  sorted value presented.
- out_ready  in  1  sink accepts the value.
- out_data  out  8  sorted value, ascending.
- out_last  out  1  final sorted value of the batch.
- busy  out  1  batch in progress.
- err  out  1  sticky watchdog error.
- h_push  out  1  heap push pulse.
- h_pop  out  1  heap pop pulse.
- h_din  out  8  heap push data.
- h_dout  in  8  heap top value.
- h_size  in  8  heap occupancy.
- h_done  in  1  heap operation complete pulse.
- h_valid  in  1  heap non-empty and idle.

Function
REQ-004 SHALL be a Moore FSM with states LOAD, PUSH_WAIT, SETTLE, PRESENT, POP_WAIT and ERR.
REQ-005 SHALL hold in_ready=1 only in LOAD with count<CAPACITY.
- On in_valid&in_ready: register in_data to h_din, pulse h_push for exactly 1 cycle, latch in_last, count+=1, go to PUSH_WAIT.
REQ-006 SHALL leave PUSH_WAIT on h_done:
- To SETTLE if the latched in_last=1 or count==CAPACITY.
- Otherwise back to LOAD.
REQ-007 SHALL spend exactly 1 cycle in SETTLE, then go to PRESENT, so that h_dout reflects the current heap top.
REQ-008 SHALL behave in PRESENT as follows:
- If h_size==0: clear count, go to LOAD.
- Else, once h_valid=1: register out_data=h_dout and out_last=(h_size==1), then assert out_valid.
REQ-009 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-010 SHALL handle out_valid&out_ready as follows:
- Drop out_valid the next cycle.
- Pulse h_pop for 1 cycle.
- Go to POP_WAIT.
- On h_done, go to SETTLE.
REQ-011 SHALL never assert h_push and h_pop in the same cycle, and never pulse either outside LOAD or PRESENT.
REQ-012 SHALL drive busy=1 whenever count!=0 or the state is not LOAD.
REQ-013 SHALL use an 8-bit count without wrap; CAPACITY caps count, and the batch is forced to drain at CAPACITY even without in_last.
REQ-014 SHALL ignore h_done outside PUSH_WAIT and POP_WAIT.

Reset
REQ-015 SHALL on reset=0 immediately set: state=LOAD, count=0, h_push=0, h_pop=0, h_din=0, out_valid=0, out_data=0, out_last=0, err=0.
REQ-016 SHALL drive in_ready=1 in the first cycle after reset release; reset asserted mid-batch abandons the batch, since the heap is reset on the same reset.

Configuration
REQ-017 SHALL compile the watchdog only when HEAP_SORT_TIMEOUT_EN is defined:
- A counter runs in PUSH_WAIT and POP_WAIT.
- Reaching DONE_TIMEOUT without h_done goes to ERR, setting err=1, in_ready=0 and out_valid=0.
- ERR is left only by reset.
REQ-018 SHALL, without HEAP_SORT_TIMEOUT_EN, tie err=0, make ERR unreachable, and wait indefinitely for h_done.

Structure
REQ-019 SHALL place the state enum, data width 8 and default CAPACITY/DONE_TIMEOUT in package heap_sort_pkg.
REQ-020 SHALL implement the watchdog as sub-module heap_sort_wdog (clk, reset, start, clear, expired), instantiated only under HEAP_SORT_TIMEOUT_EN.

Verification
REQ-021 SHALL cover a basic sort: input 7, 3, 9, 1 (last on 1) with out_ready=1 -> outputs 1, 3, 7, 9, out_last only on 9, exactly 4 h_push and 4 h_pop pulses.
REQ-022 SHALL cover output backpressure: out_ready held 0 for 10 cycles while presenting 3 -> out_valid=1, out_data=3 stable, no h_pop pulse.
REQ-023 SHALL cover the capacity limit: CAPACITY=4, stream 8, 6, 5, 2, 4 with no in_last -> in_ready=0 after the 4th value; output 2, 5, 6, 8 (last on 8); then 4 is accepted.
REQ-024 SHALL cover a single-element batch: input 0x80 with in_last -> out_data=0x80, out_last=1; busy returns to 0 after the pop's h_done.
REQ-025 SHALL cover the watchdog with HEAP_SORT_TIMEOUT_EN and DONE_TIMEOUT=64: h_done withheld after a push -> err=1 at cycle 64 and stays 1 until reset.
REQ-026 SHALL cover mid-batch reset: reset=0 asserted in POP_WAIT -> all outputs reach reset values asynchronously, and in_ready=1 after release.
